// File: rtl/comparator_integrator.sv
// comparator_integrator
// Per-channel capture stage between the GPIO comparator inputs and the VGA
// colour outputs. Each comparator bit is synchronised, then integrated in a
// saturating up/down accumulator while the display is visible. The result is
// presented as an MSB-aligned colour component per channel.
//
// Ports
//   clock_i         pixel clock, all logic on the rising edge
//   reset_n_i       synchronous active-low reset
//   comp_in_i       asynchronous comparator bits, one per channel
//   visible_i       active-video qualifier
//   mode_i          0 INTEGRATE, 1 DIRECT, 2 HOLD, 3 LINE_RESTART
//   clear_i         synchronous clear of all accumulators
//   channel_mask_i  1 forces that channel's component to 0
//   pixel_out_o     colour components, channel c at [c*OUT_W +: OUT_W]
//   pixel_valid_o   registered copy of visible_i
//   sat_hi_o        accumulator at full scale (post-update)
//   sat_lo_o        accumulator at zero (post-update)
module comparator_integrator #(
    parameter int CHANNELS    = 3,
    parameter int ACC_W       = 5,
    parameter int OUT_W       = 8,
    parameter int UP_STEP     = 1,
    parameter int DOWN_STEP   = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic                         clock_i,
    input  logic                         reset_n_i,
    input  logic [CHANNELS-1:0]          comp_in_i,
    input  logic                         visible_i,
    input  logic [1:0]                   mode_i,
    input  logic                         clear_i,
    input  logic [CHANNELS-1:0]          channel_mask_i,
    output logic [CHANNELS*OUT_W-1:0]    pixel_out_o,
    output logic                         pixel_valid_o,
    output logic [CHANNELS-1:0]          sat_hi_o,
    output logic [CHANNELS-1:0]          sat_lo_o
);

    typedef enum logic [1:0] {
        MODE_INTEGRATE = 2'd0,
        MODE_DIRECT    = 2'd1,
        MODE_HOLD      = 2'd2,
        MODE_RESTART   = 2'd3
    } mode_e;

    localparam logic [ACC_W-1:0] ACC_MAX = '1;
    // Only the MSB set: midscale, also valid for ACC_W == 1.
    localparam logic [ACC_W-1:0] ACC_MID = ACC_MAX ^ (ACC_MAX >> 1);
    localparam logic [ACC_W:0]   MAX_EXT = {1'b0, ACC_MAX};
    localparam logic [ACC_W:0]   UP_INC  = (ACC_W+1)'(UP_STEP);
    localparam logic [ACC_W:0]   DN_DEC  = (ACC_W+1)'(DOWN_STEP);

    logic [CHANNELS-1:0]       sync_q [SYNC_STAGES];
    logic [ACC_W-1:0]          acc_q  [CHANNELS];
    logic [ACC_W-1:0]          acc_d  [CHANNELS];
    logic [ACC_W:0]            sum_w  [CHANNELS];
    logic [ACC_W:0]            dif_w  [CHANNELS];
    logic                      vis_prev_q;
    logic [CHANNELS-1:0]       s_w;
    logic                      vis_rise_w;
    logic [CHANNELS*OUT_W-1:0] pix_d;
    logic [CHANNELS-1:0]       sat_hi_d;
    logic [CHANNELS-1:0]       sat_lo_d;

    always_comb begin
        s_w        = sync_q[SYNC_STAGES-1];
        vis_rise_w = visible_i & ~vis_prev_q;
        pix_d      = '0;
        sat_hi_d   = '0;
        sat_lo_d   = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            // One extra bit catches overflow on add and borrow on subtract.
            sum_w[c] = {1'b0, acc_q[c]} + UP_INC;
            dif_w[c] = {1'b0, acc_q[c]} - DN_DEC;
            acc_d[c] = acc_q[c];

            if (clear_i) begin
                acc_d[c] = '0;
            end else if (mode_i == MODE_RESTART && vis_rise_w) begin
                acc_d[c] = ACC_MID;
            end else if (!visible_i || mode_i == MODE_HOLD) begin
                acc_d[c] = acc_q[c];
            end else if (mode_i == MODE_INTEGRATE || mode_i == MODE_RESTART) begin
                if (s_w[c])
                    acc_d[c] = (sum_w[c] > MAX_EXT) ? ACC_MAX : sum_w[c][ACC_W-1:0];
                else
                    acc_d[c] = dif_w[c][ACC_W] ? '0 : dif_w[c][ACC_W-1:0];
            end

            // Component is built from the pre-update accumulator.
            if (!visible_i || channel_mask_i[c])
                pix_d[c*OUT_W +: OUT_W] = '0;
            else if (mode_i == MODE_DIRECT)
                pix_d[c*OUT_W +: OUT_W] = s_w[c] ? '1 : '0;
            else
                pix_d[c*OUT_W +: OUT_W] = OUT_W'(acc_q[c]) << (OUT_W - ACC_W);

            sat_hi_d[c] = (acc_d[c] == ACC_MAX);
            sat_lo_d[c] = (acc_d[c] == '0);
        end
    end

    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            for (int c = 0; c < CHANNELS; c++) acc_q[c] <= '0;
            vis_prev_q    <= 1'b0;
            pixel_out_o   <= '0;
            pixel_valid_o <= 1'b0;
            sat_hi_o      <= '0;
            sat_lo_o      <= '1;
        end else begin
            sync_q[0] <= comp_in_i;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            for (int c = 0; c < CHANNELS; c++) acc_q[c] <= acc_d[c];
            vis_prev_q    <= visible_i;
            pixel_out_o   <= pix_d;
            pixel_valid_o <= visible_i;
            sat_hi_o      <= sat_hi_d;
            sat_lo_o      <= sat_lo_d;
        end
    end

endmodule

// File: tb/tb_comparator_integrator.sv
module tb_comparator_integrator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  comp;
    logic        vis;
    logic [1:0]  mode;
    logic        clr;
    logic [2:0]  mask;
    logic [23:0] pix;
    logic        pv;
    logic [2:0]  hi, lo;

    logic [7:0]  p_pix;
    logic        p_pv;
    logic        p_hi, p_lo;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    comparator_integrator dut (
        .clock_i(clk), .reset_n_i(rst_n), .comp_in_i(comp), .visible_i(vis),
        .mode_i(mode), .clear_i(clr), .channel_mask_i(mask),
        .pixel_out_o(pix), .pixel_valid_o(pv), .sat_hi_o(hi), .sat_lo_o(lo)
    );

    comparator_integrator #(.CHANNELS(1), .ACC_W(4), .OUT_W(8), .UP_STEP(3),
                            .DOWN_STEP(1), .SYNC_STAGES(2)) u_p (
        .clock_i(clk), .reset_n_i(rst_n), .comp_in_i(comp[0]), .visible_i(vis),
        .mode_i(mode), .clear_i(clr), .channel_mask_i(mask[0]),
        .pixel_out_o(p_pix), .pixel_valid_o(p_pv), .sat_hi_o(p_hi), .sat_lo_o(p_lo)
    );

    typedef struct packed {
        logic [23:0] pix;
        logic        pv;
        logic [2:0]  hi;
        logic [2:0]  lo;
    } exp_t;

    exp_t exp_q[$];

    // Behavioural model of the default build (3 ch, 5-bit acc, 8-bit out).
    logic [2:0] m_s0, m_s1;
    int         m_acc [3];
    logic       m_vprev;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        exp_t e;
        int   na;
        e = '0;
        if (!rst_n) begin
            m_s0 = '0; m_s1 = '0; m_vprev = 1'b0;
            for (int c = 0; c < 3; c++) m_acc[c] = 0;
            e.lo = 3'b111;
        end else begin
            for (int c = 0; c < 3; c++) begin
                if (!vis || mask[c])      e.pix[c*8 +: 8] = 8'h00;
                else if (mode == 2'd1)    e.pix[c*8 +: 8] = m_s1[c] ? 8'hFF : 8'h00;
                else                      e.pix[c*8 +: 8] = 8'(m_acc[c] * 8);
                na = m_acc[c];
                if (clr) na = 0;
                else if (mode == 2'd3 && vis && !m_vprev) na = 16;
                else if (!vis || mode == 2'd2) na = m_acc[c];
                else if (mode == 2'd0 || mode == 2'd3) begin
                    if (m_s1[c]) na = (m_acc[c] + 1 > 31) ? 31 : m_acc[c] + 1;
                    else         na = (m_acc[c] - 1 < 0) ? 0 : m_acc[c] - 1;
                end
                m_acc[c] = na;
                e.hi[c] = (na == 31);
                e.lo[c] = (na == 0);
            end
            e.pv    = vis;
            m_s1    = m_s0;
            m_s0    = comp;
            m_vprev = vis;
        end
        exp_q.push_back(e);
    endtask

    task automatic tick();
        exp_t e;
        model_step();
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("pix",   32'(pix), 32'(e.pix));
        check("valid", 32'(pv),  32'(e.pv));
        check("sat_hi", 32'(hi), 32'(e.hi));
        check("sat_lo", 32'(lo), 32'(e.lo));
    endtask

    logic [7:0] ptab [10];

    initial begin
        ptab[0] = 8'h00; ptab[1] = 8'h00; ptab[2] = 8'h00; ptab[3] = 8'h00;
        ptab[4] = 8'h30; ptab[5] = 8'h60; ptab[6] = 8'h90; ptab[7] = 8'hC0;
        ptab[8] = 8'hF0; ptab[9] = 8'hF0;

        rst_n = 1'b0; comp = 3'b000; vis = 1'b0; mode = 2'd0; clr = 1'b0; mask = 3'b000;
        repeat (3) tick();
        check("rst_pix",   32'(pix), 32'h0);
        check("rst_valid", 32'(pv),  32'h0);
        check("rst_hi",    32'(hi),  32'h0);
        check("rst_lo",    32'(lo),  32'h7);

        // Integrate up to full scale; parameter build ramps by 3 alongside.
        rst_n = 1'b1; vis = 1'b1; comp = 3'b111;
        for (int i = 1; i <= 34; i++) begin
            tick();
            if (i <= 9) check("p_pix", 32'(p_pix), 32'(ptab[i]));
        end
        check("full_pix", 32'(pix), 32'hF8F8F8);
        check("full_hi",  32'(hi),  32'h7);
        check("p_hi",     32'(p_hi), 32'h1);
        repeat (5) tick();
        check("nowrap_pix", 32'(pix), 32'hF8F8F8);

        // Ramp down to zero.
        comp = 3'b000;
        repeat (34) tick();
        check("zero_pix", 32'(pix), 32'h0);
        check("zero_lo",  32'(lo),  32'h7);
        repeat (3) tick();
        check("nounder_lo", 32'(lo), 32'h7);

        // Direct mode with mask on channel 1.
        mode = 2'd1; mask = 3'b010; comp = 3'b111;
        repeat (3) tick();
        check("direct_pix", 32'(pix), 32'hFF00FF);
        check("direct_lo",  32'(lo),  32'h7);

        // Line restart: midscale load on visible rise.
        mode = 2'd3; mask = 3'b000; vis = 1'b0;
        tick();
        vis = 1'b1;
        tick();
        check("restart_hi", 32'(hi), 32'h0);
        check("restart_lo", 32'(lo), 32'h0);
        tick();
        check("restart_pix", 32'(pix), 32'h808080);

        // Clear wins over a restart edge.
        vis = 1'b0;
        tick();
        vis = 1'b1; clr = 1'b1;
        tick();
        check("clr_lo", 32'(lo), 32'h7);
        clr = 1'b0;
        tick();
        check("clr_pix", 32'(pix), 32'h000000);

        // Back-to-back one-cycle visible pulses each reload midscale.
        for (int k = 0; k < 3; k++) begin
            vis = 1'b0; tick();
            vis = 1'b1; tick();
        end
        vis = 1'b0; tick();
        vis = 1'b1; tick();
        check("pulse_pix", 32'(pix), 32'h808080);

        // Blanked: accumulator frozen while comparator toggles.
        mode = 2'd0; vis = 1'b0;
        for (int k = 0; k < 6; k++) begin
            comp = (k % 2 == 0) ? 3'b101 : 3'b010;
            tick();
        end
        check("blank_pix",   32'(pix), 32'h0);
        check("blank_valid", 32'(pv),  32'h0);

        // Reset in the middle of a visible line.
        vis = 1'b1; comp = 3'b111;
        repeat (4) tick();
        rst_n = 1'b0;
        tick();
        check("midrst_pix",   32'(pix), 32'h0);
        check("midrst_valid", 32'(pv),  32'h0);
        check("midrst_hi",    32'(hi),  32'h0);
        check("midrst_lo",    32'(lo),  32'h7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
